// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PIC SPI note-frame receiver.
// Frame layout: sync word, prd1, prd2, prd3, ctrl (32 bits each, MSB first).
package keyboard_pkg;

    localparam logic [31:0] SYNC_WORD_DEF   = 32'h0000_FFFF;
    localparam int          WORDS_PER_FRAME = 4;
    localparam int          PRD_W           = 32;

    typedef enum logic [1:0] {
        HUNT,
        RECV,
        CHECK,
        COMMIT
    } rx_state_t;

    typedef enum logic [1:0] {
        SQUARE,
        SAW,
        TRI,
        SINE
    } waveform_t;

    // Only the low nibble of ctrl carries meaning; anything above is corruption.
    function automatic logic ctrl_ok(input logic [31:0] c);
        return c[31:4] == 28'h0;
    endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// SPI pins in, committed note registers and status pulses out.
// master = PIC/consumer side, slave = the receiver.
interface spi_frame_rx_if;
    import keyboard_pkg::*;

    logic             sck;
    logic             sdi;
    logic [PRD_W-1:0] prd1;
    logic [PRD_W-1:0] prd2;
    logic [PRD_W-1:0] prd3;
    logic [1:0]       waveform;
    logic [1:0]       notes;
    logic             frame_valid;
    logic             frame_err;

    modport master (
        output sck,
        output sdi,
        input  prd1,
        input  prd2,
        input  prd3,
        input  waveform,
        input  notes,
        input  frame_valid,
        input  frame_err
    );

    modport slave (
        input  sck,
        input  sdi,
        output prd1,
        output prd2,
        output prd3,
        output waveform,
        output notes,
        output frame_valid,
        output frame_err
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with optional
// rising-edge detect taken from the last synchronizer stage.
module sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic q_d;

            // Remember the previous synced level to spot 0->1.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_d <= 1'b0;
                end else begin
                    q_d <= chain[STAGES-1];
                end
            end

            assign rise = chain[STAGES-1] & ~q_d;
        end else begin : g_lvl
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_frame_rx.sv
// Receives PIC SPI note frames in the clk domain and commits them atomically.
// Hunts for the sync word, captures prd1..3 + ctrl, validates, then publishes.
module spi_frame_rx
    import keyboard_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEF,
    parameter int          TIMEOUT_CYCLES = 20000,
    parameter int          SYNC_STAGES    = 2
) (
    input logic           clk,
    input logic           reset,
    spi_frame_rx_if.slave bus
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_FRAME - 1);

    logic bit_edge;
    logic sdi_s;
    logic sck_lvl_unused;
    logic sdi_rise_unused;

    rx_state_t state, state_n;

    logic [31:0]       sr, sr_n, sr_shift;
    logic [4:0]        bitcnt, bitcnt_n;
    logic [1:0]        wordcnt, wordcnt_n;
    logic [IDLE_W-1:0] idle, idle_n;
    logic [31:0]       shadow [WORDS_PER_FRAME];

    logic shadow_ld;
    logic commit;
    logic err;

    logic [PRD_W-1:0] prd1_q, prd2_q, prd3_q;
    logic [1:0]       waveform_q, notes_q;
    logic             valid_q, err_q;

    sync_edge #(
        .STAGES (SYNC_STAGES),
        .EDGE   (1'b1)
    ) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sck),
        .q     (sck_lvl_unused),
        .rise  (bit_edge)
    );

    sync_edge #(
        .STAGES (SYNC_STAGES),
        .EDGE   (1'b0)
    ) u_sdi_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sdi),
        .q     (sdi_s),
        .rise  (sdi_rise_unused)
    );

    assign sr_shift = {sr[30:0], sdi_s};

    // Receiver state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    // Framing, bit/word counting, timeout and validation decisions.
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bitcnt_n  = bitcnt;
        wordcnt_n = wordcnt;
        idle_n    = idle;
        shadow_ld = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;

        if (bit_edge) begin
            sr_n = sr_shift;
        end

        unique case (state)
            HUNT: begin
                if (bit_edge && sr_shift == SYNC_WORD) begin
                    state_n   = RECV;
                    bitcnt_n  = 5'd0;
                    wordcnt_n = 2'd0;
                    idle_n    = '0;
                end
            end
            RECV: begin
                if (bit_edge) begin
                    idle_n = '0;
                    if (bitcnt == 5'd31) begin
                        shadow_ld = 1'b1;
                        bitcnt_n  = 5'd0;
                        wordcnt_n = wordcnt + 2'd1;
                        if (wordcnt == LAST_WORD) begin
                            state_n = CHECK;
                        end
                    end else begin
                        bitcnt_n = bitcnt + 5'd1;
                    end
                end else if (idle == IDLE_LAST) begin
                    err     = 1'b1;
                    state_n = HUNT;
                end else begin
                    idle_n = idle + IDLE_W'(1);
                end
            end
            CHECK: begin
                if (ctrl_ok(shadow[WORDS_PER_FRAME-1])) begin
                    state_n = COMMIT;
                end else begin
                    err     = 1'b1;
                    state_n = HUNT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = HUNT;
            end
            default: begin
                state_n = HUNT;
            end
        endcase

        // A fresh hunt must see a whole sync word; no partial carry-over.
        if (state_n == HUNT && state != HUNT) begin
            sr_n = '0;
        end
    end

    // Shift register, counters and per-frame shadow capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bitcnt  <= '0;
            wordcnt <= '0;
            idle    <= '0;
            for (int i = 0; i < WORDS_PER_FRAME; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            sr      <= sr_n;
            bitcnt  <= bitcnt_n;
            wordcnt <= wordcnt_n;
            idle    <= idle_n;
            if (shadow_ld) begin
                shadow[wordcnt] <= sr_shift;
            end
        end
    end

    // Published registers: all fields move together on commit only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prd1_q     <= '0;
            prd2_q     <= '0;
            prd3_q     <= '0;
            waveform_q <= '0;
            notes_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= commit;
            err_q   <= err;
            if (commit) begin
                prd1_q     <= shadow[0];
                prd2_q     <= shadow[1];
                prd3_q     <= shadow[2];
                waveform_q <= shadow[3][1:0];
                notes_q    <= shadow[3][3:2];
            end
        end
    end

    assign bus.prd1        = prd1_q;
    assign bus.prd2        = prd2_q;
    assign bus.prd3        = prd3_q;
    assign bus.waveform    = waveform_q;
    assign bus.notes       = notes_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized frame-level bench for spi_frame_rx.
// Expected outputs come from a frame-level model of commit/error rules.
module tb_spi_frame_rx;

    localparam logic [31:0] SYNC = 32'h0000_FFFF;
    localparam int          TMO  = 300;

    typedef struct packed {
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
        logic [1:0]  wf;
        logic [1:0]  nt;
    } snap_t;

    logic clk;
    logic reset;

    spi_frame_rx_if bus ();

    spi_frame_rx #(
        .SYNC_WORD      (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int nvalid  = 0;
    int nerr    = 0;
    int nboth   = 0;
    int glitch  = 0;
    snap_t vq[$];
    snap_t prev = '0;

    snap_t exp_o  = '0;
    int    exp_nv = 0;
    int    exp_ne = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t cur();
        snap_t s;
        s.p1 = bus.prd1;
        s.p2 = bus.prd2;
        s.p3 = bus.prd3;
        s.wf = bus.waveform;
        s.nt = bus.notes;
        return s;
    endfunction

    // Observe pulses and output stability away from the active edge.
    always @(negedge clk) begin
        snap_t s;
        s = cur();
        if (bus.frame_valid) begin
            nvalid++;
            vq.push_back(s);
        end
        if (bus.frame_err) nerr++;
        if (bus.frame_valid && bus.frame_err) nboth++;
        if (!reset && !bus.frame_valid && s != prev) glitch++;
        prev = s;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input int half);
        bus.sdi = b;
        wait_clk(half);
        bus.sck = 1'b1;
        wait_clk(half);
        bus.sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int half);
        for (int i = 31; i >= 0; i--) send_bit(w[i], half);
    endtask

    // Frame-level reference: valid ctrl commits all fields, else one error.
    task automatic model_frame(input logic [31:0] p1, input logic [31:0] p2,
                               input logic [31:0] p3, input logic [31:0] c);
        if ((c >> 4) == 32'h0) begin
            exp_o.p1 = p1;
            exp_o.p2 = p2;
            exp_o.p3 = p3;
            exp_o.wf = c[1:0];
            exp_o.nt = c[3:2];
            exp_nv++;
        end else begin
            exp_ne++;
        end
    endtask

    task automatic send_frame(input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] p3, input logic [31:0] c,
                              input int half);
        send_word(SYNC, half);
        send_word(p1, half);
        send_word(p2, half);
        send_word(p3, half);
        send_word(c, half);
        model_frame(p1, p2, p3, c);
    endtask

    task automatic check_all(input string tag);
        snap_t s;
        s = cur();
        check({tag, ".prd1"}, 64'(s.p1), 64'(exp_o.p1));
        check({tag, ".prd2"}, 64'(s.p2), 64'(exp_o.p2));
        check({tag, ".prd3"}, 64'(s.p3), 64'(exp_o.p3));
        check({tag, ".wave"}, 64'(s.wf), 64'(exp_o.wf));
        check({tag, ".notes"}, 64'(s.nt), 64'(exp_o.nt));
        check({tag, ".nvalid"}, 64'(nvalid), 64'(exp_nv));
        check({tag, ".nerr"}, 64'(nerr), 64'(exp_ne));
    endtask

    initial begin
        int lat;
        int e0;
        logic [31:0] r1, r2, r3, rc;

        reset   = 1'b1;
        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        wait_clk(3);
        check_all("reset");
        reset = 1'b0;
        wait_clk(3);

        // Basic frame.
        send_frame(32'd1000, 32'd2000, 32'd3000, 32'h0000_000D, 5);
        wait_clk(20);
        check_all("t1");
        check("t1.wave_lit", 64'(bus.waveform), 64'd1);
        check("t1.notes_lit", 64'(bus.notes), 64'd3);

        // Bad ctrl: error only, outputs held.
        send_frame(32'd11, 32'd22, 32'd33, 32'h0001_000D, 4);
        wait_clk(20);
        check_all("t2");

        // Timeout after 40 bits.
        send_word(SYNC, 5);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 5);
        e0  = nerr;
        lat = -1;
        for (int i = 0; i < 2 * TMO; i++) begin
            wait_clk(1);
            if (nerr != e0) begin
                lat = i + 1;
                break;
            end
        end
        exp_ne++;
        check("t3.tmo_seen", 64'(lat > 0), 64'd1);
        check("t3.tmo_window", 64'(lat >= TMO - 10 && lat <= TMO + 10), 64'd1);
        wait_clk(5);
        check_all("t3.after_tmo");
        send_frame(32'h1234, 32'h5678, 32'h9ABC, 32'h0000_0006, 6);
        wait_clk(20);
        check_all("t3.recover");

        // Sync pattern as payload is just data.
        send_frame(32'hAAAA_0001, SYNC, 32'h0BAD_F00D, 32'h0000_0003, 4);
        wait_clk(20);
        check_all("t4");

        // Reset mid-frame, async output clear.
        send_word(SYNC, 5);
        send_word(32'hDEAD_BEEF, 5);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 5);
        #1 reset = 1'b1;
        #1;
        exp_o  = '0;
        check_all("t5.async");
        wait_clk(3);
        reset = 1'b0;
        bus.sck = 1'b0;
        wait_clk(3);
        send_frame(32'd440, 32'd554, 32'd659, 32'h0000_000E, 5);
        wait_clk(20);
        check_all("t5.after");

        // Back-to-back frames at sck period 8 clk.
        vq.delete();
        send_frame(32'h100, 32'h200, 32'h300, 32'h0000_0004, 4);
        send_frame(32'h111, 32'h222, 32'h333, 32'h0000_000B, 4);
        wait_clk(20);
        check_all("t6");
        check("t6.pulses", 64'(vq.size()), 64'd2);
        if (vq.size() == 2) begin
            check("t6.first_p1", 64'(vq[0].p1), 64'h100);
            check("t6.first_nt", 64'(vq[0].nt), 64'd1);
            check("t6.second_p3", 64'(vq[1].p3), 64'h333);
        end

        // Randomized frames, some with corrupt ctrl.
        for (int k = 0; k < 6; k++) begin
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            rc = ($urandom_range(0, 2) == 0) ? $urandom | 32'h100
                                             : 32'($urandom_range(0, 15));
            send_frame(r1, r2, r3, rc, $urandom_range(4, 7));
            wait_clk(20);
            check_all($sformatf("rand%0d", k));
        end

        check("never_both", 64'(nboth), 64'd0);
        check("stable", 64'(glitch), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
